branch_sequencer: RTL
=====================

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: the clock is clk_i and the reset is rst_i.
REQ-002 clk_i  in  1  clock; all state changes on the rising edge.
REQ-003 rst_i  in  1  synchronous active-high reset.
REQ-004 start_i  in  1  one-cycle request to sequence a branch; ignored unless busy_o=0.
REQ-005 abort_i  in  1  pipeline flush; cancels the branch in flight.
REQ-006 ir_i  in  8  opcode (70h-7Fh, E0h-E3h, EBh); sampled with start_i.
REQ-007 big_i  in  1  1 = 32-bit address/count size, 0 = 16-bit; sampled with start_i.
REQ-008 disp_i  in  8  signed disp8; sampled with start_i.
REQ-009 eip_i  in  32  EIP of the next sequential instruction; sampled with start_i.
REQ-010 ecx_i  in  32  current ECX; sampled with start_i.
REQ-011 zf_i, cf_i, sf_i, vf_i, pf_i  in  1 each  flags; sampled with start_i.
REQ-012 busy_o  out  1  high in every state except IDLE.
REQ-013 ecx_we_o  out  1  one-cycle ECX write strobe.
REQ-014 ecx_o  out  32  ECX write value.
REQ-015 redir_valid_o  out  1  fetch-redirect request valid.
REQ-016 redir_ready_i  in  1  fetch accepts the redirect.
REQ-017 redir_eip_o  out  32  branch target EIP.
REQ-018 done_o  out  1  one-cycle completion pulse.
REQ-019 taken_o  out  1  branch decision; valid while done_o=1.

Function
REQ-020 FSM states SHALL be IDLE, DECR, EVAL, REDIR and DONE.
REQ-021 In IDLE with start_i=1, the block SHALL latch all sampled inputs; next state is DECR for E0h/E1h/E2h and EVAL for every other opcode.
REQ-022 In DECR, ecx_we_o=1 and ecx_o = latched ECX - 1; when big=0, only bits 15:0 decrement (FFFFh wraps from 0000h) and bits 31:16 are preserved; the latched count updates; next state is EVAL.
REQ-023 In EVAL, the decision SHALL use the latched flags and latched (post-decrement for LOOPs) count with x86 Jcc/JCXZ/LOOP/LOOPZ/LOOPNZ/JMPS semantics; an unrecognised opcode is not taken; the decision and target are registered.
REQ-024 The target SHALL be latched EIP + sign-extended disp; when big=0, the target is (EIP[15:0] + sext(disp)) mod 2^16, zero-extended.
REQ-025 From EVAL, next state is REDIR if taken and DONE if not taken.
REQ-026 In REDIR, redir_valid_o=1 and redir_eip_o holds stable until redir_valid_o & redir_ready_i; on that cycle, next state is DONE.
REQ-027 In DONE, done_o=1 for exactly one cycle and taken_o reflects the decision; next state is IDLE.
REQ-028 Latency from the start_i edge to done_o SHALL be: not-taken non-LOOP = 2 cycles; taken non-LOOP with ready held high = 3 cycles; LOOP forms add 1 cycle.
REQ-029 abort_i=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done_o, no further ecx_we_o and redir_valid_o dropped; an ECX write already issued is not undone.
REQ-030 abort_i SHALL have priority over redir_ready_i in the same cycle.
REQ-031 start_i asserted while busy_o=1 SHALL be ignored and not queued.
REQ-032 In IDLE with start_i=1 and abort_i=1, the block SHALL remain in IDLE.

Reset
REQ-033 rst_i=1 SHALL force IDLE and clear all outputs: busy_o, ecx_we_o, redir_valid_o, done_o and taken_o are 0; ecx_o and redir_eip_o are 0.
REQ-034 Reset mid-operation SHALL discard the branch in flight without a done_o pulse; reset takes priority over abort_i and start_i.

Structure
REQ-035 Opcode constants (JO..JNLE, LOOPNZ, LOOPZ, LOOP, JCXZ, JMPS) and the FSM state enum SHALL live in the shared cpu_386 package.
REQ-036 The condition decode SHALL be one instantiated sub-module, evaluate_branch, fed from the latched registers.

Verification
REQ-037 JE (74h), zf=1, eip=00001000h, disp=10h, big=1, ready=1 -> redir_eip_o=00001010h; done_o 3 cycles after start; taken_o=1.
REQ-038 JNE (75h), zf=1 -> no redir_valid_o; done_o 2 cycles after start; taken_o=0.
REQ-039 LOOP (E2h), big=0, ecx=12340001h -> ecx_we_o with ecx_o=12340000h; not taken. Repeat with ecx=12340000h -> ecx_o=1234FFFFh; taken.
REQ-040 JMPS (EBh), big=0, eip=0000FFF0h, disp=20h -> redir_eip_o=00000010h.
REQ-041 JA (77h) taken with ready held low 5 cycles -> redir_valid_o and the target stay stable; done_o one cycle after ready rises. Repeat with abort_i in cycle 3 -> IDLE, no done_o.
REQ-042 rst_i asserted during REDIR -> next cycle all outputs 0 and busy_o=0; a start_i during busy is ignored.

Source files
------------

// File: rtl/cpu_386_pkg.sv
// Shared 386 definitions: branch opcodes, sequencer state encoding and the
// count-decrement helper used by the LOOP family.
package cpu_386;

  localparam logic [7:0] JO     = 8'h70;
  localparam logic [7:0] JNO    = 8'h71;
  localparam logic [7:0] JB     = 8'h72;
  localparam logic [7:0] JNB    = 8'h73;
  localparam logic [7:0] JE     = 8'h74;
  localparam logic [7:0] JNE    = 8'h75;
  localparam logic [7:0] JBE    = 8'h76;
  localparam logic [7:0] JNBE   = 8'h77;
  localparam logic [7:0] JS     = 8'h78;
  localparam logic [7:0] JNS    = 8'h79;
  localparam logic [7:0] JP     = 8'h7A;
  localparam logic [7:0] JNP    = 8'h7B;
  localparam logic [7:0] JL     = 8'h7C;
  localparam logic [7:0] JNL    = 8'h7D;
  localparam logic [7:0] JLE    = 8'h7E;
  localparam logic [7:0] JNLE   = 8'h7F;
  localparam logic [7:0] LOOPNZ = 8'hE0;
  localparam logic [7:0] LOOPZ  = 8'hE1;
  localparam logic [7:0] LOOP   = 8'hE2;
  localparam logic [7:0] JCXZ   = 8'hE3;
  localparam logic [7:0] JMPS   = 8'hEB;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DECR  = 3'd1,
    S_EVAL  = 3'd2,
    S_REDIR = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic is_loop(input logic [7:0] ir);
    return (ir == LOOPNZ) || (ir == LOOPZ) || (ir == LOOP);
  endfunction

  // 16-bit mode only touches CX; the upper half of ECX rides through unchanged.
  function automatic logic [31:0] cnt_dec(input logic [31:0] ecx, input logic big);
    return big ? (ecx - 32'd1) : {ecx[31:16], ecx[15:0] - 16'd1};
  endfunction

endpackage

// File: rtl/evaluate_branch.sv
// Combinational branch decision and target computation from latched state.
// Covers Jcc, JCXZ/JECXZ, LOOP/LOOPZ/LOOPNZ and JMPS; other opcodes are not taken.
module evaluate_branch
  import cpu_386::*;
(
  input  logic [7:0]  ir_i,
  input  logic        big_i,
  input  logic [7:0]  disp_i,
  input  logic [31:0] eip_i,
  input  logic [31:0] cnt_i,
  input  logic        zf_i,
  input  logic        cf_i,
  input  logic        sf_i,
  input  logic        vf_i,
  input  logic        pf_i,
  output logic        taken_o,
  output logic [31:0] target_o
);

  logic [31:0] w_sext;
  logic [15:0] w_tgt16;
  logic        w_cnt_zero;
  logic        w_cc;

  assign w_sext     = {{24{disp_i[7]}}, disp_i};
  assign w_tgt16    = eip_i[15:0] + w_sext[15:0];
  assign target_o   = big_i ? (eip_i + w_sext) : {16'h0000, w_tgt16};
  assign w_cnt_zero = big_i ? (cnt_i == 32'd0) : (cnt_i[15:0] == 16'd0);

  // Even Jcc opcodes test the condition, odd ones its complement.
  always_comb begin
    w_cc = 1'b0;
    case (ir_i[3:1])
      3'd0: w_cc = vf_i;
      3'd1: w_cc = cf_i;
      3'd2: w_cc = zf_i;
      3'd3: w_cc = cf_i | zf_i;
      3'd4: w_cc = sf_i;
      3'd5: w_cc = pf_i;
      3'd6: w_cc = sf_i ^ vf_i;
      default: w_cc = zf_i | (sf_i ^ vf_i);
    endcase
  end

  always_comb begin
    taken_o = 1'b0;
    if (ir_i[7:4] == 4'h7) begin
      taken_o = w_cc ^ ir_i[0];
    end else begin
      case (ir_i)
        LOOPNZ:  taken_o = !w_cnt_zero && !zf_i;
        LOOPZ:   taken_o = !w_cnt_zero && zf_i;
        LOOP:    taken_o = !w_cnt_zero;
        JCXZ:    taken_o = w_cnt_zero;
        JMPS:    taken_o = 1'b1;
        default: taken_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle branch sequencer: optional count decrement, decision, fetch
// redirect handshake and a one-cycle completion pulse; abort flushes at any point.
module branch_sequencer
  import cpu_386::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [7:0]  ir_i,
  input  logic        big_i,
  input  logic [7:0]  disp_i,
  input  logic [31:0] eip_i,
  input  logic [31:0] ecx_i,
  input  logic        zf_i,
  input  logic        cf_i,
  input  logic        sf_i,
  input  logic        vf_i,
  input  logic        pf_i,
  output logic        busy_o,
  output logic        ecx_we_o,
  output logic [31:0] ecx_o,
  output logic        redir_valid_o,
  input  logic        redir_ready_i,
  output logic [31:0] redir_eip_o,
  output logic        done_o,
  output logic        taken_o
);

  state_t      r_state;
  logic [7:0]  r_ir;
  logic        r_big;
  logic [7:0]  r_disp;
  logic [31:0] r_eip;
  logic [31:0] r_cnt;
  logic        r_zf, r_cf, r_sf, r_vf, r_pf;
  logic        r_busy;
  logic        r_ecx_we;
  logic [31:0] r_ecx;
  logic        r_redir_vld;
  logic [31:0] r_redir_eip;
  logic        r_done;
  logic        r_taken;
  logic        w_taken;
  logic [31:0] w_target;

  evaluate_branch u_eval (
    .ir_i     (r_ir),
    .big_i    (r_big),
    .disp_i   (r_disp),
    .eip_i    (r_eip),
    .cnt_i    (r_cnt),
    .zf_i     (r_zf),
    .cf_i     (r_cf),
    .sf_i     (r_sf),
    .vf_i     (r_vf),
    .pf_i     (r_pf),
    .taken_o  (w_taken),
    .target_o (w_target)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_ir        <= '0;
      r_big       <= 1'b0;
      r_disp      <= '0;
      r_eip       <= '0;
      r_cnt       <= '0;
      {r_zf, r_cf, r_sf, r_vf, r_pf} <= '0;
      r_busy      <= 1'b0;
      r_ecx_we    <= 1'b0;
      r_ecx       <= '0;
      r_redir_vld <= 1'b0;
      r_redir_eip <= '0;
      r_done      <= 1'b0;
      r_taken     <= 1'b0;
    end else begin
      r_ecx_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            r_ir   <= ir_i;
            r_big  <= big_i;
            r_disp <= disp_i;
            r_eip  <= eip_i;
            r_cnt  <= ecx_i;
            {r_zf, r_cf, r_sf, r_vf, r_pf} <= {zf_i, cf_i, sf_i, vf_i, pf_i};
            r_busy <= 1'b1;
            if (is_loop(ir_i)) begin
              // Strobe is registered so it lines up with the DECR state.
              r_state  <= S_DECR;
              r_ecx_we <= 1'b1;
              r_ecx    <= cnt_dec(ecx_i, big_i);
            end else begin
              r_state <= S_EVAL;
            end
          end
        end
        S_DECR: begin
          if (abort_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt   <= r_ecx;
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (abort_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_taken     <= w_taken;
            r_redir_eip <= w_target;
            if (w_taken) begin
              r_state     <= S_REDIR;
              r_redir_vld <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_REDIR: begin
          if (abort_i) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_redir_vld <= 1'b0;
          end else if (redir_ready_i) begin
            r_state     <= S_DONE;
            r_redir_vld <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = r_busy;
  assign ecx_we_o      = r_ecx_we;
  assign ecx_o         = r_ecx;
  assign redir_valid_o = r_redir_vld;
  assign redir_eip_o   = r_redir_eip;
  assign done_o        = r_done;
  assign taken_o       = r_taken;

endmodule
